// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: RUN / MEMWAIT / ERROR FSM with a memory-wait timeout.
// Optional saturating performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LDRstall,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] BrFlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt,
`endif
  output logic [1:0]       CtrlState
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       in_err, mem_wait, br_flush, ld_stall;

  // Decode priority: error > memory wait > branch > load-use > idle.
  always_comb begin
    in_err   = state_q[1];
    mem_wait = 1'b0;
    if (!in_err) begin
      if (state_q == MEMWAIT) mem_wait = !MemReadyM;
      else                    mem_wait = MemReqM && !MemReadyM;
    end
    br_flush = !in_err && !mem_wait && PCSrcE;
    ld_stall = !in_err && !mem_wait && !PCSrcE && LDRstall;

    StallF    = in_err || mem_wait || ld_stall;
    StallD    = in_err || mem_wait || ld_stall;
    StallE    = in_err || mem_wait;
    StallM    = in_err || mem_wait;
    FlushW    = in_err || mem_wait;
    FlushD    = br_flush;
    FlushE    = br_flush || ld_stall;
    MemErr    = in_err;
    CtrlState = state_q;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = 8'd0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        if (MemReadyM)                state_d = RUN;
        else if (wcnt_q == WAIT_LAST) state_d = ERROR;
        else                          wcnt_d  = wcnt_q + 8'd1;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] ld_cnt_q, br_cnt_q, mw_cnt_q;

  // Counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= '0;
      br_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      if (ld_stall && !(&ld_cnt_q)) ld_cnt_q <= ld_cnt_q + CNT_W'(1);
      if (br_flush && !(&br_cnt_q)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (mem_wait && !(&mw_cnt_q)) mw_cnt_q <= mw_cnt_q + CNT_W'(1);
    end
  end

  assign LdStallCnt = ld_cnt_q;
  assign BrFlushCnt = br_cnt_q;
  assign MemWaitCnt = mw_cnt_q;
`endif

endmodule
